// File: rtl/uart_pkg.sv
// Shared types, default widths and the parity helper for the buffered UART transmitter.
// The optional parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_BRD_W     = 16;
    localparam int unsigned DEF_STOP_BITS = 1;
    localparam int unsigned MAX_DATA_W    = 9;
    localparam int unsigned BIT_CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Callers zero-extend narrower characters; the extra zeros do not change the XOR.
    function automatic logic parity_f(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; provides full/empty flags and occupancy.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned W     = DEF_DATA_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wr_data_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + (AW+1)'(1);
        if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o   = wptr_q - rptr_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, baud-divided serialiser with sticky overflow status.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit after the data bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned BRD_W     = DEF_BRD_W,
    parameter int unsigned STOP_BITS = DEF_STOP_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [BRD_W-1:0]         baud_div,
    input  logic                     clr_ovf,
`ifdef UART_TX_PARITY_EN
    input  logic                     parity_odd,
`endif
    output logic                     tx,
    output logic                     Ff,
    output logic                     Fe,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     done_t
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e             state_q;
    logic                  tx_q, busy_q, done_q;
    logic                  ovf_q, ovf_d;
    logic [BRD_W-1:0]      baud_cnt_q, div_q;
    logic [DATA_W-1:0]     shreg_q, rd_data;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  stop_cnt_q;
    logic                  pop, push, tick;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
`endif

    assign pop  = (state_q == IDLE) && !Fe;
    assign push = wr_en && (!Ff || pop);
    assign tick = (baud_cnt_q == div_q);

    uart_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data),
        .full_o    (Ff),
        .empty_o   (Fe),
        .level_o   (level)
    );

    always_comb begin
        ovf_d = (ovf_q && !clr_ovf) || (wr_en && !push);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    // tx/busy/done are updated on the same edge as the state they belong to,
    // so the serial line changes exactly at each bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) baud_cnt_q <= tick ? '0 : baud_cnt_q + BRD_W'(1);
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shreg_q    <= rd_data;
                        div_q      <= baud_div;
                        baud_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                        par_q      <= parity_f(MAX_DATA_W'(rd_data), parity_odd);
`endif
                        state_q    <= START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        tx_q      <= shreg_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q    <= PARITY;
                            tx_q       <= par_q;
`else
                            state_q    <= STOP;
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 1'b0;
`endif
                        end else begin
                            shreg_q   <= shreg_q >> 1;
                            tx_q      <= shreg_q[1];
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_q    <= STOP;
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (stop_cnt_q == LAST_STOP) begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign busy   = busy_q;
    assign done_t = done_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4): reset, framing, overflow, full push+pop, async reset.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [15:0] baud_div = '0;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd = 1'b0;
`endif
    logic        tx, Ff, Fe, ovf, busy, done_t;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;
    int frame_errs = 0;
    logic [7:0] rxq [$];
    logic       parq [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .BRD_W     (16),
        .STOP_BITS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .baud_div  (baud_div),
        .clr_ovf   (clr_ovf),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx        (tx),
        .Ff        (Ff),
        .Fe        (Fe),
        .ovf       (ovf),
        .level     (level),
        .busy      (busy),
        .done_t    (done_t)
    );

    // Serial receiver: samples each slot near its centre, aborts if reset is seen.
    initial begin : monitor
        int p;
        int t;
        logic [7:0] d;
        logic pb;
        bit abort;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                p = int'(baud_div) + 1;
                d = '0;
                pb = 1'b0;
                abort = 1'b0;
                t = 1;
                for (int i = 0; i < DW + PBITS + 1; i++) begin
                    while (t < 1 + p * (1 + i) + p / 2) begin
                        @(negedge clk);
                        t++;
                        if (!rst) abort = 1'b1;
                    end
                    if (i < DW) d[i] = tx;
                    else if (PBITS == 1 && i == DW) pb = tx;
                    else if (!abort && tx !== 1'b1) frame_errs++;
                end
                if (!abort) begin
                    rxq.push_back(d);
                    parq.push_back(pb);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (Fe !== 1'b1)   begin errors++; $display("FAIL reset_Fe: got %b expected 1", Fe); end
        checks++; if (Ff !== 1'b0)   begin errors++; $display("FAIL reset_Ff: got %b expected 0", Ff); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (done_t !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_t); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1 || Fe !== 1'b1)
            begin errors++; $display("FAIL post_reset_idle: busy=%b tx=%b Fe=%b expected 0 1 1", busy, tx, Fe); end
    endtask

    task automatic test_single_frame;
        logic [7:0] pat;
        logic e;
        int slot;
        pat = 8'h55;
        baud_div = 16'd3;
        rxq.delete();
        wr_data = 8'h55;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (Fe !== 1'b0 || level !== 3'd1)
            begin errors++; $display("FAIL sf_pushed: Fe=%b level=%0d expected 0 1", Fe, level); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL sf_no_bypass: tx=%b expected 1", tx); end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            slot = (k - 1) / 4;
            if (slot == 0)      e = 1'b0;
            else if (slot <= 8) e = pat[slot-1];
            else                e = 1'b1;
            checks++; if (tx !== e)
                begin errors++; $display("FAIL sf_bit k=%0d: tx=%b expected %b", k, tx, e); end
            checks++; if (done_t !== 1'b0)
                begin errors++; $display("FAIL sf_done_early k=%0d: done_t=%b expected 0", k, done_t); end
        end
        @(negedge clk);
        checks++; if (done_t !== 1'b1) begin errors++; $display("FAIL sf_done41: done_t=%b expected 1", done_t); end
        checks++; if (busy !== 1'b0 || Fe !== 1'b1)
            begin errors++; $display("FAIL sf_end_idle: busy=%b Fe=%b expected 0 1", busy, Fe); end
        @(negedge clk);
        checks++; if (done_t !== 1'b0) begin errors++; $display("FAIL sf_done_pulse: done_t=%b expected 0", done_t); end
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h55)
            begin errors++; $display("FAIL sf_rx: n=%0d first=%h expected 1 55", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx); end
    endtask

    task automatic test_fill_overflow;
        baud_div = 16'd15;
        rxq.delete();
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (Ff !== 1'b1 || level !== 3'd4 || ovf !== 1'b0)
            begin errors++; $display("FAIL fo_full: Ff=%b level=%0d ovf=%b expected 1 4 0", Ff, level, ovf); end
        wr_data = 8'h06;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (ovf !== 1'b1 || level !== 3'd4)
            begin errors++; $display("FAIL fo_ovf_set: ovf=%b level=%0d expected 1 4", ovf, level); end
        wr_data = 8'h07;
        wr_en = 1'b1;
        clr_ovf = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (ovf !== 1'b1)
            begin errors++; $display("FAIL fo_clr_vs_new: ovf=%b expected 1", ovf); end
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fo_clr: ovf=%b expected 0", ovf); end
        for (int c = 0; c < 1000 && rxq.size() < 5; c++) @(negedge clk);
        checks++; if (rxq.size() != 5)
            begin errors++; $display("FAIL fo_frames: got %0d frames expected 5", rxq.size()); end
        for (int i = 0; i < 5 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== 8'(i + 1))
                begin errors++; $display("FAIL fo_order[%0d]: got %h expected %h", i, rxq[i], 8'(i + 1)); end
        end
        repeat (20) @(negedge clk);
        checks++; if (Fe !== 1'b1 || level !== 3'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL fo_drained: Fe=%b level=%0d busy=%b expected 1 0 0", Fe, level, busy); end
    endtask

    task automatic test_push_pop_full;
        baud_div = 16'd1;
        rxq.delete();
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'hA0 + 8'(i);
            wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (Ff !== 1'b1 || level !== 3'd4)
            begin errors++; $display("FAIL ppf_full: Ff=%b level=%0d expected 1 4", Ff, level); end
        for (int c = 0; c < 200 && busy !== 1'b0; c++) @(negedge clk);
        checks++; if (busy !== 1'b0 || Ff !== 1'b1)
            begin errors++; $display("FAIL ppf_idle_seen: busy=%b Ff=%b expected 0 1", busy, Ff); end
        wr_data = 8'hA6;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (level !== 3'd4 || Ff !== 1'b1 || ovf !== 1'b0)
            begin errors++; $display("FAIL ppf_swap: level=%0d Ff=%b ovf=%b expected 4 1 0", level, Ff, ovf); end
        checks++; if (busy !== 1'b1 || tx !== 1'b0)
            begin errors++; $display("FAIL ppf_b2b: busy=%b tx=%b expected 1 0", busy, tx); end
        for (int c = 0; c < 300 && rxq.size() < 6; c++) @(negedge clk);
        checks++; if (rxq.size() != 6)
            begin errors++; $display("FAIL ppf_frames: got %0d frames expected 6", rxq.size()); end
        for (int i = 0; i < 6 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== 8'hA1 + 8'(i))
                begin errors++; $display("FAIL ppf_order[%0d]: got %h expected %h", i, rxq[i], 8'hA1 + 8'(i)); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        bit glitch;
        baud_div = 16'd3;
        rxq.delete();
        wr_data = 8'h00;
        wr_en = 1'b1;
        @(negedge clk);
        wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (17) @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || Fe !== 1'b0)
            begin errors++; $display("FAIL rm_in_bit3: tx=%b busy=%b Fe=%b expected 0 1 0", tx, busy, Fe); end
        #2 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rm_async_tx: tx=%b expected 1", tx); end
        checks++; if (busy !== 1'b0 || Fe !== 1'b1 || level !== 3'd0)
            begin errors++; $display("FAIL rm_async_state: busy=%b Fe=%b level=%0d expected 0 1 0", busy, Fe, level); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        glitch = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) glitch = 1'b1;
        end
        checks++; if (glitch) begin errors++; $display("FAIL rm_residual: line activity seen after reset, expected idle"); end
        checks++; if (Fe !== 1'b1 || rxq.size() != 0)
            begin errors++; $display("FAIL rm_discard: Fe=%b frames=%0d expected 1 0", Fe, rxq.size()); end
        repeat (50) @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        baud_div = 16'd1;
        rxq.delete();
        parq.delete();
        parity_odd = 1'b0;
        wr_data = 8'h07;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 100 && rxq.size() < 1; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        parity_odd = 1'b1;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 100 && rxq.size() < 2; c++) @(negedge clk);
        checks++; if (rxq.size() != 2)
            begin errors++; $display("FAIL par_frames: got %0d expected 2", rxq.size()); end
        else begin
            checks++; if (rxq[0] !== 8'h07 || parq[0] !== 1'b1)
                begin errors++; $display("FAIL par_even: data=%h par=%b expected 07 1", rxq[0], parq[0]); end
            checks++; if (rxq[1] !== 8'h07 || parq[1] !== 1'b0)
                begin errors++; $display("FAIL par_odd: data=%h par=%b expected 07 0", rxq[1], parq[1]); end
        end
        repeat (10) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_fill_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++; if (frame_errs != 0)
            begin errors++; $display("FAIL stop_bits: %0d bad stop bits expected 0", frame_errs); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
